// File: rtl/pzcorebus_response_packet_fifo.sv
// Burst-aware response FIFO for the pzcorebus response path (slave side -> master side).
// With PACKET_MODE a burst is released upstream only once its last beat is stored, unless the FIFO fills up.
module pzcorebus_response_packet_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter bit EVERY_BEAT_LAST = 1'b0,
    parameter int DEPTH           = 4,
    parameter int THRESHOLD       = DEPTH,
    parameter bit PACKET_MODE     = 1'b1,
    parameter bit FLAG_FF_OUT     = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clear,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_word_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_packet_count,
    output logic                         slave_sresp_valid_o,
    output logic [DATA_WIDTH-1:0]        slave_sresp_o,
    output logic                         slave_sresp_last_o,
    input  logic                         slave_maccept_i,
    input  logic                         master_sresp_valid_i,
    input  logic [DATA_WIDTH-1:0]        master_sresp_i,
    input  logic                         master_sresp_last_i,
    output logic                         master_maccept_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2) begin : g_depth_check
        $error("pzcorebus_response_packet_fifo: DEPTH must be at least 2");
    end
    if (THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_threshold_check
        $error("pzcorebus_response_packet_fifo: THRESHOLD must be within 1..DEPTH");
    end

    typedef enum logic {
        ST_WAIT    = 1'b0,
        ST_FORWARD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       wrPtr_q, wrPtr_d;
    logic [PW-1:0]       rdPtr_q, rdPtr_d;
    logic [CW-1:0]       wordCount_q, wordCount_d;
    logic [CW-1:0]       packetCount_q, packetCount_d;
    logic [DATA_WIDTH:0] mem_q [DEPTH];

    logic                emptyFlag;
    logic                fullFlag;
    logic                almostFullFlag;
    logic                push;
    logic                pop;
    logic                inLast;
    logic                headLast;
    logic                slaveValid;
    logic [DATA_WIDTH:0] headEntry;

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign inLast    = EVERY_BEAT_LAST ? 1'b1 : master_sresp_last_i;
    assign headEntry = mem_q[rdPtr_q];
    assign headLast  = headEntry[DATA_WIDTH];

    assign master_maccept_o = !fullFlag;
    assign push             = master_sresp_valid_i && !fullFlag;
    assign pop              = slaveValid && slave_maccept_i;

    // In WAIT a beat is offered only when a whole burst is buffered, or when the FIFO is
    // full and must release a partial burst to avoid deadlock.
    always_comb begin
        slaveValid = !emptyFlag;
        if (PACKET_MODE && state_q == ST_WAIT) begin
            slaveValid = !emptyFlag && ((packetCount_q != '0) || fullFlag);
        end
    end

    always_comb begin
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        wordCount_d   = wordCount_q;
        packetCount_d = packetCount_q;
        state_d       = state_q;
        if (i_clear) begin
            wrPtr_d       = '0;
            rdPtr_d       = '0;
            wordCount_d   = '0;
            packetCount_d = '0;
            state_d       = ST_WAIT;
        end else begin
            if (push) begin
                wrPtr_d = incPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = incPtr(rdPtr_q);
            end
            case ({push, pop})
                2'b10:   wordCount_d = wordCount_q + CW'(1);
                2'b01:   wordCount_d = wordCount_q - CW'(1);
                default: wordCount_d = wordCount_q;
            endcase
            case ({push && inLast, pop && headLast})
                2'b10:   packetCount_d = packetCount_q + CW'(1);
                2'b01:   packetCount_d = packetCount_q - CW'(1);
                default: packetCount_d = packetCount_q;
            endcase
            if (PACKET_MODE) begin
                case (state_q)
                    ST_WAIT:    if (pop && !headLast) state_d = ST_FORWARD;
                    ST_FORWARD: if (pop && headLast)  state_d = ST_WAIT;
                    default:    state_d = ST_WAIT;
                endcase
            end else begin
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            wordCount_q   <= '0;
            packetCount_q <= '0;
            state_q       <= ST_WAIT;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            wordCount_q   <= wordCount_d;
            packetCount_q <= packetCount_d;
            state_q       <= state_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {inLast, master_sresp_i};
        end
    end

    if (FLAG_FF_OUT) begin : g_flag_ff
        logic empty_q;
        logic full_q;
        logic almostFull_q;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                empty_q      <= 1'b1;
                full_q       <= 1'b0;
                almostFull_q <= 1'b0;
            end else begin
                empty_q      <= (wordCount_d == '0);
                full_q       <= (wordCount_d == CW'(DEPTH));
                almostFull_q <= (wordCount_d >= CW'(THRESHOLD));
            end
        end

        assign emptyFlag      = empty_q;
        assign fullFlag       = full_q;
        assign almostFullFlag = almostFull_q;
    end else begin : g_flag_decode
        assign emptyFlag      = (wordCount_q == '0);
        assign fullFlag       = (wordCount_q == CW'(DEPTH));
        assign almostFullFlag = (wordCount_q >= CW'(THRESHOLD));
    end

    assign o_empty             = emptyFlag;
    assign o_full              = fullFlag;
    assign o_almost_full       = almostFullFlag;
    assign o_word_count        = wordCount_q;
    assign o_packet_count      = packetCount_q;
    assign slave_sresp_valid_o = slaveValid;
    assign slave_sresp_o       = headEntry[DATA_WIDTH-1:0];
    assign slave_sresp_last_o  = headLast;

endmodule

// File: tb/tb_pzcorebus_response_packet_fifo.sv
// Bench for pzcorebus_response_packet_fifo: a store-and-forward instance and a plain FIFO instance
// share one stimulus stream; a scoreboard per instance checks delivered beats in order.
module tb_pzcorebus_response_packet_fifo;

    localparam int DW = 8;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          inValid;
    logic [DW-1:0] inData;
    logic          inLast;
    logic          outAccept;

    logic          pktEmpty, pktAfull, pktFull, pktValid, pktLast, pktMaccept;
    logic [CW-1:0] pktWc, pktPc;
    logic [DW-1:0] pktData;
    logic          plnEmpty, plnAfull, plnFull, plnValid, plnLast, plnMaccept;
    logic [CW-1:0] plnWc, plnPc;
    logic [DW-1:0] plnData;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [DW:0] sbPkt[$];
    logic [DW:0] sbPlain[$];

    always #5 clock = ~clock;

    pzcorebus_response_packet_fifo #(
        .DATA_WIDTH(DW), .EVERY_BEAT_LAST(1'b0), .DEPTH(4), .THRESHOLD(3),
        .PACKET_MODE(1'b1), .FLAG_FF_OUT(1'b1)
    ) dutPkt (
        .i_clk(clock), .i_rst(reset), .i_clear(clear),
        .o_empty(pktEmpty), .o_almost_full(pktAfull), .o_full(pktFull),
        .o_word_count(pktWc), .o_packet_count(pktPc),
        .slave_sresp_valid_o(pktValid), .slave_sresp_o(pktData),
        .slave_sresp_last_o(pktLast), .slave_maccept_i(outAccept),
        .master_sresp_valid_i(inValid), .master_sresp_i(inData),
        .master_sresp_last_i(inLast), .master_maccept_o(pktMaccept)
    );

    pzcorebus_response_packet_fifo #(
        .DATA_WIDTH(DW), .EVERY_BEAT_LAST(1'b0), .DEPTH(4), .THRESHOLD(3),
        .PACKET_MODE(1'b0), .FLAG_FF_OUT(1'b0)
    ) dutPlain (
        .i_clk(clock), .i_rst(reset), .i_clear(clear),
        .o_empty(plnEmpty), .o_almost_full(plnAfull), .o_full(plnFull),
        .o_word_count(plnWc), .o_packet_count(plnPc),
        .slave_sresp_valid_o(plnValid), .slave_sresp_o(plnData),
        .slave_sresp_last_o(plnLast), .slave_maccept_i(outAccept),
        .master_sresp_valid_i(inValid), .master_sresp_i(inData),
        .master_sresp_last_i(inLast), .master_maccept_o(plnMaccept)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l, input logic acc);
        inValid   = v;
        inData    = d;
        inLast    = l;
        outAccept = acc;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic waitPktPush(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            if (pktMaccept) done = 1'b1;
            nextCycle();
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic drainPkt(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clock);
            if (pktEmpty && plnEmpty) done = 1'b1;
            else nextCycle();
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    // Scoreboards: pops are matched first since a push is never visible in the same cycle.
    always @(negedge clock) begin
        if (reset || clear) begin
            sbPkt.delete();
            sbPlain.delete();
        end else begin
            if (pktValid && outAccept) begin
                checkOutput("pkt_pop_expected", {31'd0, sbPkt.size() != 0}, 32'd1);
                if (sbPkt.size() != 0) checkOutput("pkt_beat", {23'd0, pktLast, pktData}, {23'd0, sbPkt.pop_front()});
            end
            if (plnValid && outAccept) begin
                checkOutput("plain_pop_expected", {31'd0, sbPlain.size() != 0}, 32'd1);
                if (sbPlain.size() != 0) checkOutput("plain_beat", {23'd0, plnLast, plnData}, {23'd0, sbPlain.pop_front()});
            end
            if (inValid && pktMaccept) sbPkt.push_back({inLast, inData});
            if (inValid && plnMaccept) sbPlain.push_back({inLast, inData});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        checkOutput("rst_empty", {31'd0, pktEmpty}, 32'd1);
        checkOutput("rst_wc", {29'd0, pktWc}, 32'd0);
        checkOutput("rst_pc", {29'd0, pktPc}, 32'd0);
        checkOutput("rst_maccept", {31'd0, pktMaccept}, 32'd1);
        checkOutput("rst_valid", {31'd0, pktValid}, 32'd0);
        checkOutput("rst_full", {31'd0, pktFull}, 32'd0);
        checkOutput("rst_plain_empty", {31'd0, plnEmpty}, 32'd1);
        checkOutput("rst_plain_valid", {31'd0, plnValid}, 32'd0);
        nextCycle();

        // Three-beat burst held until its last beat arrives
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        @(negedge clock); checkOutput("b3_valid_c0", {31'd0, pktValid}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b1);
        @(negedge clock); checkOutput("b3_valid_c1", {31'd0, pktValid}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 8'h13, 1'b1, 1'b1);
        @(negedge clock); checkOutput("b3_valid_c2", {31'd0, pktValid}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("b3_valid_c3", {31'd0, pktValid}, 32'd1);
        checkOutput("b3_pc_c3", {29'd0, pktPc}, 32'd1);
        checkOutput("b3_wc_c3", {29'd0, pktWc}, 32'd3);
        repeat (3) nextCycle();
        @(negedge clock);
        checkOutput("b3_wc_end", {29'd0, pktWc}, 32'd0);
        checkOutput("b3_pc_end", {29'd0, pktPc}, 32'd0);
        checkOutput("b3_empty_end", {31'd0, pktEmpty}, 32'd1);
        nextCycle();

        // Six-beat burst into a four-entry FIFO: full escape
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("b6_full", {31'd0, pktFull}, 32'd1);
        checkOutput("b6_maccept", {31'd0, pktMaccept}, 32'd0);
        checkOutput("b6_valid", {31'd0, pktValid}, 32'd1);
        checkOutput("b6_wc", {29'd0, pktWc}, 32'd4);
        checkOutput("b6_afull", {31'd0, pktAfull}, 32'd1);
        checkOutput("b6_pc", {29'd0, pktPc}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b1);
        waitPktPush("b6_push4_timeout");
        applyStimulus(1'b1, 8'h35, 1'b1, 1'b1);
        waitPktPush("b6_push5_timeout");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        drainPkt("b6_drain_timeout");
        checkOutput("b6_wc_end", {29'd0, pktWc}, 32'd0);
        checkOutput("b6_pc_end", {29'd0, pktPc}, 32'd0);
        checkOutput("b6_sb_empty", sbPkt.size(), 32'd0);
        nextCycle();

        // Plain mode: single beat visible the next cycle; packet mode holds it back
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("plain_no_passthru", {31'd0, plnValid}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("plain_valid_n1", {31'd0, plnValid}, 32'd1);
        checkOutput("plain_wc_n1", {29'd0, plnWc}, 32'd1);
        checkOutput("pkt_wait_partial", {31'd0, pktValid}, 32'd0);
        checkOutput("pkt_wc_partial", {29'd0, pktWc}, 32'd1);

        // Threshold 3: simultaneous push and pop leave the count unchanged
        applyStimulus(1'b1, 8'h51, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 8'h52, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("thr_wc_2", {29'd0, plnWc}, 32'd2);
        checkOutput("thr_afull_2", {31'd0, plnAfull}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 8'h53, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("thr_wc_pushpop", {29'd0, plnWc}, 32'd2);
        checkOutput("thr_afull_pushpop", {31'd0, plnAfull}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("thr_wc_3", {29'd0, plnWc}, 32'd3);
        checkOutput("thr_afull_3", {31'd0, plnAfull}, 32'd1);
        checkOutput("thr_full_3", {31'd0, plnFull}, 32'd0);
        checkOutput("pkt_full_escape_wc", {29'd0, pktWc}, 32'd4);

        clear = 1'b1;
        nextCycle();
        clear = 1'b0;
        @(negedge clock);
        checkOutput("clr_empty", {31'd0, pktEmpty}, 32'd1);
        checkOutput("clr_plain_wc", {29'd0, plnWc}, 32'd0);

        // Partial burst in FORWARD, then clear together with a push
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (2) nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("fwd_wc", {29'd0, pktWc}, 32'd2);
        checkOutput("fwd_valid", {31'd0, pktValid}, 32'd1);
        applyStimulus(1'b1, 8'h6F, 1'b0, 1'b0);
        clear = 1'b1;
        nextCycle();
        clear = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("clr2_empty", {31'd0, pktEmpty}, 32'd1);
        checkOutput("clr2_wc", {29'd0, pktWc}, 32'd0);
        checkOutput("clr2_pc", {29'd0, pktPc}, 32'd0);
        checkOutput("clr2_valid", {31'd0, pktValid}, 32'd0);
        checkOutput("clr2_maccept", {31'd0, pktMaccept}, 32'd1);
        checkOutput("clr2_plain_empty", {31'd0, plnEmpty}, 32'd1);
        applyStimulus(1'b1, 8'h70, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("clr2_state_wait", {31'd0, pktValid}, 32'd0);
        checkOutput("clr2_wc_after", {29'd0, pktWc}, 32'd1);
        applyStimulus(1'b1, 8'h71, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        drainPkt("clr2_drain_timeout");
        checkOutput("clr2_sb_pkt_empty", sbPkt.size(), 32'd0);
        checkOutput("clr2_sb_plain_empty", sbPlain.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
